// File: rtl/fetch_stage_if.sv
// Fetch-stage port bundle: instruction-memory port, pipeline control and IF/ID outputs.
// The master side is the fetch stage itself; the slave side is memory plus the rest of the core.
interface fetch_stage_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] imem_addr_o;
    logic [DATA_WIDTH-1:0] imem_rdata_i;
    logic                  stall_i;
    logic                  redirect_i;
    logic [ADDR_WIDTH-1:0] redirect_pc_i;
    logic                  dec_ready_i;
    logic                  ifid_valid_o;
    logic [DATA_WIDTH-1:0] ifid_instr_o;
    logic [ADDR_WIDTH-1:0] ifid_pc_o;
    logic [ADDR_WIDTH-1:0] ifid_pcplus4_o;
    logic                  fault_o;
    logic [ADDR_WIDTH-1:0] fault_pc_o;
    logic [31:0]           fetch_count_o;

    modport master (
        output imem_addr_o,
        input  imem_rdata_i,
        input  stall_i,
        input  redirect_i,
        input  redirect_pc_i,
        input  dec_ready_i,
        output ifid_valid_o,
        output ifid_instr_o,
        output ifid_pc_o,
        output ifid_pcplus4_o,
        output fault_o,
        output fault_pc_o,
        output fetch_count_o
    );

    modport slave (
        input  imem_addr_o,
        output imem_rdata_i,
        output stall_i,
        output redirect_i,
        output redirect_pc_i,
        output dec_ready_i,
        input  ifid_valid_o,
        input  ifid_instr_o,
        input  ifid_pc_o,
        input  ifid_pcplus4_o,
        input  fault_o,
        input  fault_pc_o,
        input  fetch_count_o
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a RUN/HOLD/FAULT controller
// that fetches only from the ROM window and flags a sticky fault on an out-of-window PC.
module fetch_stage #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC00000,
    parameter int unsigned           ROM_BYTES  = 4096
) (
    input logic           clk_i,
    input logic           rst_i,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
    // One extra bit so the window bounds cannot wrap at the top of the address space.
    localparam logic [ADDR_WIDTH:0]   ROM_LO    = {1'b0, RESET_PC};
    localparam logic [ADDR_WIDTH:0]   ROM_HI    = ROM_LO + (ADDR_WIDTH+1)'(ROM_BYTES)
                                                  - (ADDR_WIDTH+1)'(4);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  ifid_valid_q, ifid_valid_d;
    logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
    logic [ADDR_WIDTH-1:0] ifid_pcplus4_q, ifid_pcplus4_d;
    logic                  fault_q, fault_d;
    logic [ADDR_WIDTH-1:0] fault_pc_q, fault_pc_d;
    logic [31:0]           fetch_count_q, fetch_count_d;

    logic pc_legal;
    logic fire;
    logic ifid_hold;
    logic fault_set;
    logic drain;

    assign pc_legal = (pc_q[1:0] == 2'b00)
                   && ({1'b0, pc_q} >= ROM_LO)
                   && ({1'b0, pc_q} <= ROM_HI);

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (bus.redirect_i) begin
            state_d = ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.stall_i) begin
                        state_d = ST_HOLD;
                    end else if (!pc_legal) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_HOLD: begin
                    if (!bus.stall_i) begin
                        state_d = ST_RUN;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // ---------------- output / control logic ----------------
    always_comb begin
        fire      = 1'b0;
        ifid_hold = 1'b0;
        fault_set = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                fire      = !bus.redirect_i && !bus.stall_i && pc_legal
                         && (!ifid_valid_q || bus.dec_ready_i);
                fault_set = !bus.redirect_i && !bus.stall_i && !pc_legal;
                ifid_hold = bus.stall_i;
            end
            ST_HOLD:  ifid_hold = 1'b1;
            ST_FAULT: ifid_hold = bus.stall_i;
            default: begin
                fire      = 1'b0;
                ifid_hold = 1'b0;
                fault_set = 1'b0;
            end
        endcase
        // Decode took the current entry and nothing replaces it.
        drain = ifid_valid_q && bus.dec_ready_i && !ifid_hold && !fire;
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        pc_d           = pc_q;
        ifid_valid_d   = ifid_valid_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_pc_d      = ifid_pc_q;
        ifid_pcplus4_d = ifid_pcplus4_q;
        fault_d        = fault_q;
        fault_pc_d     = fault_pc_q;
        fetch_count_d  = fetch_count_q;

        if (bus.redirect_i) begin
            pc_d         = bus.redirect_pc_i;
            ifid_valid_d = 1'b0;
            fault_d      = 1'b0;
        end else if (fire) begin
            pc_d           = pc_q + PC_STEP;
            ifid_valid_d   = 1'b1;
            ifid_instr_d   = bus.imem_rdata_i;
            ifid_pc_d      = pc_q;
            ifid_pcplus4_d = pc_q + PC_STEP;
            fetch_count_d  = fetch_count_q + 32'd1;
        end else begin
            if (drain) begin
                ifid_valid_d = 1'b0;
            end
            if (fault_set) begin
                fault_d    = 1'b1;
                fault_pc_d = pc_q;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q           <= RESET_PC;
            ifid_valid_q   <= 1'b0;
            ifid_instr_q   <= NOP_INSTR;
            ifid_pc_q      <= '0;
            ifid_pcplus4_q <= '0;
            fault_q        <= 1'b0;
            fault_pc_q     <= '0;
            fetch_count_q  <= '0;
        end else begin
            pc_q           <= pc_d;
            ifid_valid_q   <= ifid_valid_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pc_q      <= ifid_pc_d;
            ifid_pcplus4_q <= ifid_pcplus4_d;
            fault_q        <= fault_d;
            fault_pc_q     <= fault_pc_d;
            fetch_count_q  <= fetch_count_d;
        end
    end

    assign bus.imem_addr_o    = pc_q;
    assign bus.ifid_valid_o   = ifid_valid_q;
    assign bus.ifid_instr_o   = ifid_instr_q;
    assign bus.ifid_pc_o      = ifid_pc_q;
    assign bus.ifid_pcplus4_o = ifid_pcplus4_q;
    assign bus.fault_o        = fault_q;
    assign bus.fault_pc_o     = fault_pc_q;
    assign bus.fetch_count_o  = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized control traffic
// compared cycle by cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam logic [31:0] RESET_PC   = 32'hBFC00000;
    localparam int unsigned ROM_BYTES  = 4096;
    localparam logic [31:0] ROM_LAST   = RESET_PC + 32'(ROM_BYTES) - 32'd4;

    typedef struct packed {
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic        fault;
        logic [31:0] fault_pc;
        logic [31:0] count;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_stage_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    fetch_stage #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .RESET_PC  (RESET_PC),
        .ROM_BYTES (ROM_BYTES)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    // Instruction memory: a fixed scrambled word per address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0013;
    endfunction

    assign bus.imem_rdata_i = rom_word(bus.imem_addr_o);

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_fault_pc, m_count;
    logic        m_valid, m_fault;
    logic        m_stall_echo;  // a stall freezes the stage for its own cycles plus one more

    function automatic bit in_window(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && (pc >= RESET_PC) && (pc <= ROM_LAST);
    endfunction

    task automatic model_reset();
        m_pc         = RESET_PC;
        m_valid      = 1'b0;
        m_instr      = 32'h0000_0013;
        m_ipc        = '0;
        m_ipc4       = '0;
        m_fault      = 1'b0;
        m_fault_pc   = '0;
        m_count      = '0;
        m_stall_echo = 1'b0;
    endtask

    task automatic model_step(input bit stall, input bit redir, input logic [31:0] rpc, input bit rdy);
        if (redir) begin
            m_pc         = rpc;
            m_valid      = 1'b0;
            m_fault      = 1'b0;
            m_stall_echo = 1'b0;
        end else if (m_fault) begin
            if (rdy && !stall) m_valid = 1'b0;
        end else if (m_stall_echo) begin
            m_stall_echo = stall;
        end else if (stall) begin
            m_stall_echo = 1'b1;
        end else if (!in_window(m_pc)) begin
            m_fault    = 1'b1;
            m_fault_pc = m_pc;
            if (rdy) m_valid = 1'b0;
        end else if (!m_valid || rdy) begin
            m_valid = 1'b1;
            m_instr = rom_word(m_pc);
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_count = m_count + 32'd1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
    endtask

    function automatic obs_t dut_obs();
        return '{bus.imem_addr_o, bus.ifid_valid_o, bus.ifid_instr_o, bus.ifid_pc_o,
                 bus.ifid_pcplus4_o, bus.fault_o, bus.fault_pc_o, bus.fetch_count_o};
    endfunction

    function automatic obs_t model_obs();
        return '{m_pc, m_valid, m_instr, m_ipc, m_ipc4, m_fault, m_fault_pc, m_count};
    endfunction

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic cycle(input bit stall, input bit redir, input logic [31:0] rpc, input bit rdy);
        bus.stall_i       = stall;
        bus.redirect_i    = redir;
        bus.redirect_pc_i = rpc;
        bus.dec_ready_i   = rdy;
        model_step(stall, redir, rpc, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.dec_ready_i   = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.stall_i       = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.dec_ready_i   = 1'b1;
        #1 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_obs() !== model_obs()) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", dut_obs(), model_obs());
        end
        @(posedge clk);
        #1;
        checks++;
        if (dut_obs() !== model_obs()) begin
            errors++;
            $display("FAIL reset_held: got %h want %h", dut_obs(), model_obs());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            checks++;
            if (bus.ifid_pc_o !== RESET_PC + 32'(4 * i) || bus.ifid_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL seq_pc[%0d]: got pc %h valid %b want pc %h valid 1",
                         i, bus.ifid_pc_o, bus.ifid_valid_o, RESET_PC + 32'(4 * i));
            end
            checks++;
            if (bus.ifid_instr_o !== rom_word(RESET_PC + 32'(4 * i))) begin
                errors++;
                $display("FAIL seq_instr[%0d]: got %h want %h",
                         i, bus.ifid_instr_o, rom_word(RESET_PC + 32'(4 * i)));
            end
        end
        checks++;
        if (bus.fetch_count_o !== 32'd4 || bus.ifid_pcplus4_o !== RESET_PC + 32'd16) begin
            errors++;
            $display("FAIL seq_count: got count %0d pcplus4 %h want 4 %h",
                     bus.fetch_count_o, bus.ifid_pcplus4_o, RESET_PC + 32'd16);
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (2) cycle(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b1);
            checks++;
            if (bus.ifid_pc_o !== 32'hBFC00004 || bus.imem_addr_o !== 32'hBFC00008 ||
                bus.ifid_valid_o !== 1'b1 || bus.fetch_count_o !== 32'd2) begin
                errors++;
                $display("FAIL stall_frozen[%0d]: got pc %h addr %h valid %b count %0d want BFC00004 BFC00008 1 2",
                         i, bus.ifid_pc_o, bus.imem_addr_o, bus.ifid_valid_o, bus.fetch_count_o);
            end
        end
        cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (dut_obs() !== model_obs()) begin
            errors++;
            $display("FAIL stall_release: got %h want %h", dut_obs(), model_obs());
        end
        cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (bus.ifid_pc_o !== 32'hBFC00008 || bus.fetch_count_o !== 32'd3 ||
            bus.ifid_instr_o !== rom_word(32'hBFC00008)) begin
            errors++;
            $display("FAIL stall_resume: got pc %h count %0d instr %h want BFC00008 3 %h",
                     bus.ifid_pc_o, bus.fetch_count_o, bus.ifid_instr_o, rom_word(32'hBFC00008));
        end
    endtask

    task automatic test_redirect_in_stall();
        logic [31:0] cnt;
        cycle(1'b1, 1'b0, '0, 1'b1);
        cnt = bus.fetch_count_o;
        cycle(1'b1, 1'b1, 32'hBFC00100, 1'b1);
        checks++;
        if (bus.ifid_valid_o !== 1'b0 || bus.imem_addr_o !== 32'hBFC00100 || bus.fetch_count_o !== cnt) begin
            errors++;
            $display("FAIL redir_stall: got valid %b addr %h count %0d want 0 BFC00100 %0d",
                     bus.ifid_valid_o, bus.imem_addr_o, bus.fetch_count_o, cnt);
        end
        cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (bus.ifid_pc_o !== 32'hBFC00100 || bus.ifid_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL redir_target: got pc %h valid %b want BFC00100 1",
                     bus.ifid_pc_o, bus.ifid_valid_o);
        end
    endtask

    task automatic test_run_to_end();
        do_reset();
        repeat (1024) cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (bus.ifid_pc_o !== ROM_LAST || bus.imem_addr_o !== 32'hBFC01000 ||
            bus.fetch_count_o !== 32'd1024 || bus.fault_o !== 1'b0) begin
            errors++;
            $display("FAIL end_last: got pc %h addr %h count %0d fault %b want %h BFC01000 1024 0",
                     bus.ifid_pc_o, bus.imem_addr_o, bus.fetch_count_o, bus.fault_o, ROM_LAST);
        end
        repeat (2) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            checks++;
            if (bus.fault_o !== 1'b1 || bus.fault_pc_o !== 32'hBFC01000 || bus.imem_addr_o !== 32'hBFC01000 ||
                bus.fetch_count_o !== 32'd1024 || bus.ifid_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL end_fault: got fault %b fpc %h addr %h count %0d valid %b want 1 BFC01000 BFC01000 1024 0",
                         bus.fault_o, bus.fault_pc_o, bus.imem_addr_o, bus.fetch_count_o, bus.ifid_valid_o);
            end
        end
        cycle(1'b0, 1'b1, RESET_PC, 1'b1);
        checks++;
        if (bus.fault_o !== 1'b0 || bus.imem_addr_o !== RESET_PC) begin
            errors++;
            $display("FAIL end_clear: got fault %b addr %h want 0 %h", bus.fault_o, bus.imem_addr_o, RESET_PC);
        end
        cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (bus.ifid_pc_o !== RESET_PC || bus.fetch_count_o !== 32'd1025) begin
            errors++;
            $display("FAIL end_refetch: got pc %h count %0d want %h 1025",
                     bus.ifid_pc_o, bus.fetch_count_o, RESET_PC);
        end
    endtask

    task automatic test_bad_redirect();
        logic [31:0] cnt;
        cnt = bus.fetch_count_o;
        cycle(1'b0, 1'b1, 32'hBFC00002, 1'b1);
        checks++;
        if (bus.fault_o !== 1'b0 || bus.ifid_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL misalign_redir: got fault %b valid %b want 0 0", bus.fault_o, bus.ifid_valid_o);
        end
        repeat (2) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            checks++;
            if (bus.fault_o !== 1'b1 || bus.fault_pc_o !== 32'hBFC00002 ||
                bus.ifid_valid_o !== 1'b0 || bus.fetch_count_o !== cnt) begin
                errors++;
                $display("FAIL misalign_fault: got fault %b fpc %h valid %b count %0d want 1 BFC00002 0 %0d",
                         bus.fault_o, bus.fault_pc_o, bus.ifid_valid_o, bus.fetch_count_o, cnt);
            end
        end
    endtask

    task automatic test_backpressure_reset();
        obs_t held;
        do_reset();
        cycle(1'b0, 1'b0, '0, 1'b1);
        held = dut_obs();
        repeat (2) begin
            cycle(1'b0, 1'b0, '0, 1'b0);
            checks++;
            if (dut_obs() !== held || held.valid !== 1'b1 || held.pc !== RESET_PC) begin
                errors++;
                $display("FAIL backpressure_hold: got %h want %h", dut_obs(), held);
            end
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_obs() !== model_obs()) begin
            errors++;
            $display("FAIL reset_mid_hold: got %h want %h", dut_obs(), model_obs());
        end
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (bus.ifid_pc_o !== RESET_PC || bus.ifid_valid_o !== 1'b1 || bus.fetch_count_o !== 32'd1) begin
            errors++;
            $display("FAIL reset_first_fire: got pc %h valid %b count %0d want %h 1 1",
                     bus.ifid_pc_o, bus.ifid_valid_o, bus.fetch_count_o, RESET_PC);
        end
        // Reset out of FAULT with a redirect pending.
        cycle(1'b0, 1'b1, 32'h0000_1000, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hBFC00200;
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_obs() !== model_obs()) begin
            errors++;
            $display("FAIL reset_mid_fault: got %h want %h", dut_obs(), model_obs());
        end
        @(posedge clk);
        #1 rst = 1'b0;
        bus.redirect_i = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        bit          st, rd, rdy;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            st  = ($urandom_range(0, 4) == 0);
            rd  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: rpc = RESET_PC + 32'(4 * $urandom_range(0, 1023));
                6, 7:             rpc = RESET_PC + 32'(ROM_BYTES) - 32'(4 * $urandom_range(0, 3));
                8:                rpc = RESET_PC + 32'($urandom_range(0, 4095)) | 32'd1;
                default:          rpc = RESET_PC - 32'd4;
            endcase
            cycle(st, rd, rpc, rdy);
            checks++;
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", n, dut_obs(), model_obs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_in_stall();
        test_run_to_end();
        test_bad_redirect();
        test_backpressure_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
